// File: rtl/metro_line_ctrl.sv
// metro_line_ctrl: metro line controller.
// A train starts at a switch-selected station, dwells DWELL_TICKS cycles per
// station and bounces between the line ends. Station LEDs are one-hot, and a
// multiplexed 7-seg display scrolls the current station name.
// Optional feature macro: HOLD_EN. When it is defined, the module gains a
// `hold` input that freezes the dwell counter while the train is in DWELL.
module metro_line_ctrl #(
  parameter int N_STA    = 6,
  parameter int N_DIG    = 4,
  parameter int NAME_MAX = 10,
  parameter logic [8*NAME_MAX*N_STA-1:0] NAMES = {
    {8{8'h00}}, "TN",
    {7{8'h00}}, "YDB",
    {5{8'h00}}, "GARAJ",
    "SPORSALONU",
    {5{8'h00}}, "BAHCE",
    {3{8'h00}}, "ANABINA"},
  parameter logic [8*N_STA-1:0] LENS = {8'd2, 8'd3, 8'd5, 8'd10, 8'd5, 8'd7},
  parameter int unsigned DWELL_TICKS  = 32'd2400000000,
  parameter int unsigned SCROLL_TICKS = 32'd100000000,
  parameter int unsigned MUX_TICKS    = 32'd100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_STA-1:0]         sta_sel,
  input  logic                     dir_init,
  input  logic                     start,
`ifdef HOLD_EN
  input  logic                     hold,
`endif
  output logic [N_STA-1:0]         led_out,
  output logic [N_DIG-1:0]         an,
  output logic [6:0]               seg,
  output logic [$clog2(N_STA)-1:0] sta_idx,
  output logic                     dir,
  output logic                     arrive
);

  localparam int IW = $clog2(N_STA);
  localparam int DW = $clog2(DWELL_TICKS);
  localparam int SW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam int MW = (MUX_TICKS > 1) ? $clog2(MUX_TICKS) : 1;
  localparam int PW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int OW = (NAME_MAX > 1) ? $clog2(NAME_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_MOVE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           dir_q, dir_d;
  logic           arrive_q, arrive_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [SW-1:0]  scnt_q, scnt_d;
  logic [OW-1:0]  off_q, off_d;
  logic [MW-1:0]  mcnt_q, mcnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [N_DIG-1:0] an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic [7:0]     cur_len;
  logic           hold_w;

`ifdef HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // Highest set switch selects the start station.
  function automatic logic [IW-1:0] highest_bit(input logic [N_STA-1:0] v);
    highest_bit = '0;
    for (int i = 0; i < N_STA; i++)
      if (v[i]) highest_bit = IW'(i);
  endfunction

  // Character to active-high segment pattern (a..g = bit 6..0).
  function automatic logic [6:0] glyph(input logic [7:0] c);
    case (c)
      "A": glyph = 7'h77;
      "B": glyph = 7'h1F;
      "C": glyph = 7'h4E;
      "D": glyph = 7'h3D;
      "E": glyph = 7'h4F;
      "G": glyph = 7'h5E;
      "H": glyph = 7'h37;
      "I": glyph = 7'h06;
      "J": glyph = 7'h3C;
      "L": glyph = 7'h0E;
      "N": glyph = 7'h76;
      "O": glyph = 7'h7E;
      "P": glyph = 7'h67;
      "R": glyph = 7'h46;
      "S": glyph = 7'h5B;
      "T": glyph = 7'h0F;
      "U": glyph = 7'h3E;
      "Y": glyph = 7'h3B;
      default: glyph = 7'h00;
    endcase
  endfunction

  assign cur_len = LENS[8*int'(idx_q) +: 8];

  // Train FSM: start selection, dwell timing and bounce at the line ends.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    arrive_d = 1'b0;
    dwell_d  = dwell_q;
    unique case (state_q)
      S_IDLE: begin
        dwell_d = '0;
        if (start && (sta_sel != '0)) begin
          idx_d    = highest_bit(sta_sel);
          dir_d    = dir_init;
          arrive_d = 1'b1;
          state_d  = S_DWELL;
        end
      end
      S_DWELL: begin
        if (!hold_w) begin
          if (dwell_q == DW'(DWELL_TICKS - 2)) begin
            dwell_d = '0;
            state_d = S_MOVE;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      S_MOVE: begin
        dwell_d  = '0;
        arrive_d = 1'b1;
        state_d  = S_DWELL;
        // Flip direction before stepping if the step would leave the line.
        if (!dir_q) begin
          if (idx_q == IW'(N_STA - 1)) begin
            dir_d = 1'b1;
            idx_d = idx_q - 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          if (idx_q == '0) begin
            dir_d = 1'b0;
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scroll offset and digit scan pointer next-state.
  always_comb begin
    scnt_d = scnt_q;
    off_d  = off_q;
    mcnt_d = mcnt_q;
    ptr_d  = ptr_q;
    if ((state_q == S_IDLE) || arrive_d) begin
      scnt_d = '0;
      off_d  = '0;
    end else if (scnt_q == SW'(SCROLL_TICKS - 1)) begin
      scnt_d = '0;
      // Names shorter than the display stay put.
      if (int'(cur_len) >= N_DIG)
        off_d = (int'(off_q) >= int'(cur_len) - 1) ? '0 : off_q + 1'b1;
    end else begin
      scnt_d = scnt_q + 1'b1;
    end
    if (mcnt_q == MW'(MUX_TICKS - 1)) begin
      mcnt_d = '0;
      ptr_d  = (ptr_q == PW'(N_DIG - 1)) ? '0 : ptr_q + 1'b1;
    end else begin
      mcnt_d = mcnt_q + 1'b1;
    end
  end

  // Glyph for the digit currently pointed at; blank in IDLE or past name end.
  always_comb begin
    int   len;
    int   pos;
    logic blank;
    logic [7:0] ch;
    len   = int'(cur_len);
    pos   = int'(off_q) + N_DIG - 1 - int'(ptr_q);
    blank = (state_q == S_IDLE);
    ch    = 8'h00;
    if (pos >= len) begin
      if (len < N_DIG) blank = 1'b1;
      else             pos   = pos - len;
    end
    if (!blank)
      ch = NAMES[8*NAME_MAX*int'(idx_q) + 8*(len - 1 - pos) +: 8];
    an_d  = ~(N_DIG'(1) << ptr_q);
    seg_d = blank ? 7'h7F : ~glyph(ch);
  end

  // FSM and station state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      dir_q    <= 1'b0;
      arrive_q <= 1'b0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      arrive_q <= arrive_d;
      dwell_q  <= dwell_d;
    end
  end

  // Scroll/scan counters and registered display pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scnt_q <= '0;
      off_q  <= '0;
      mcnt_q <= '0;
      ptr_q  <= '0;
      an_q   <= '1;
      seg_q  <= 7'h7F;
    end else begin
      scnt_q <= scnt_d;
      off_q  <= off_d;
      mcnt_q <= mcnt_d;
      ptr_q  <= ptr_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign led_out = (state_q == S_IDLE) ? '0 : (N_STA'(1) << idx_q);
  assign an      = an_q;
  assign seg     = seg_q;
  assign sta_idx = idx_q;
  assign dir     = dir_q;
  assign arrive  = arrive_q;

endmodule

// File: tb/tb_metro_line_ctrl.sv
// Directed testbench for metro_line_ctrl (N_STA=6, N_DIG=4, DWELL=8,
// SCROLL=2, MUX=1, default station names).
module tb_metro_line_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] sta_sel = '0;
  logic       dir_init = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic [5:0] led_out;
  logic [3:0] an;
  logic [6:0] seg;
  logic [2:0] sta_idx;
  logic       dir;
  logic       arrive;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;
  string names [6] = '{"ANABINA", "BAHCE", "SPORSALONU", "GARAJ", "YDB", "TN"};

  metro_line_ctrl #(
    .N_STA(6), .N_DIG(4), .DWELL_TICKS(8), .SCROLL_TICKS(2), .MUX_TICKS(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sta_sel(sta_sel),
    .dir_init(dir_init),
    .start(start),
`ifdef HOLD_EN
    .hold(hold),
`endif
    .led_out(led_out),
    .an(an),
    .seg(seg),
    .sta_idx(sta_idx),
    .dir(dir),
    .arrive(arrive)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (rst_n) ncyc++;
    else       ncyc = 0;
    #1;
  endtask

  function automatic logic [6:0] glyph_of(input logic [7:0] c);
    case (c)
      "A": return 7'h77;  "B": return 7'h1F;  "C": return 7'h4E;
      "D": return 7'h3D;  "E": return 7'h4F;  "G": return 7'h5E;
      "H": return 7'h37;  "I": return 7'h06;  "J": return 7'h3C;
      "L": return 7'h0E;  "N": return 7'h76;  "O": return 7'h7E;
      "P": return 7'h67;  "R": return 7'h46;  "S": return 7'h5B;
      "T": return 7'h0F;  "U": return 7'h3E;  "Y": return 7'h3B;
      default: return 7'h00;
    endcase
  endfunction

  // Anode pattern after the ncyc-th edge since reset release.
  function automatic logic [3:0] exp_an();
    return ~(4'b0001 << ((ncyc - 1) % 4));
  endfunction

  // Segment pins for station s, scroll offset o, digit k.
  function automatic logic [6:0] exp_seg(input int s, input int o, input int k);
    int L;
    int p;
    L = names[s].len();
    p = o + 3 - k;
    if (L < 4 && p >= L) return 7'h7F;
    p = p % L;
    return ~glyph_of(names[s][p]);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sta_sel = '0;
    repeat (3) tick();
    checks++; if (led_out !== 6'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led_out); end
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want F", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7F", seg); end
    checks++; if (sta_idx !== 3'd0 || dir !== 1'b0 || arrive !== 1'b0) begin
      errors++; $display("FAIL reset_state: got idx=%0d dir=%b arr=%b want 0 0 0", sta_idx, dir, arrive); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (led_out !== 6'h00 || arrive !== 1'b0) begin
        errors++; $display("FAIL idle_stay: got led=%h arr=%b want 00 0", led_out, arrive); end
      checks++; if (an !== exp_an() || seg !== 7'h7F) begin
        errors++; $display("FAIL idle_scan: got an=%h seg=%h want an=%h seg=7F", an, seg, exp_an()); end
    end
    start = 1'b1; sta_sel = '0;
    repeat (3) tick();
    checks++; if (led_out !== 6'h00 || arrive !== 1'b0) begin
      errors++; $display("FAIL start_nosel: got led=%h arr=%b want 00 0", led_out, arrive); end
    start = 1'b0;
  endtask

  task automatic test_start_dwell();
    sta_sel = 6'b000110; dir_init = 1'b0; start = 1'b1;
    tick();
    checks++; if (sta_idx !== 3'd2 || led_out !== 6'b000100 || arrive !== 1'b1 || dir !== 1'b0) begin
      errors++; $display("FAIL start_entry: got idx=%0d led=%b arr=%b dir=%b want 2 000100 1 0", sta_idx, led_out, arrive, dir); end
    sta_sel = 6'b100000;  // ignored outside IDLE
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        checks++; if (arrive !== 1'b0) begin errors++; $display("FAIL dwell_quiet: cycle %0d got arr=%b want 0", i, arrive); end
      end else begin
        checks++; if (arrive !== 1'b1 || sta_idx !== 3'd3 || led_out !== 6'b001000) begin
          errors++; $display("FAIL dwell_next: got arr=%b idx=%0d led=%b want 1 3 001000", arrive, sta_idx, led_out); end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_bounce();
    int exp_idx [6] = '{4, 3, 2, 1, 0, 1};
    logic exp_dir [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    sta_sel = 6'b100000; dir_init = 1'b0; start = 1'b1;
    tick();
    checks++; if (sta_idx !== 3'd5 || dir !== 1'b0 || arrive !== 1'b1 || led_out !== 6'b100000) begin
      errors++; $display("FAIL bounce_start: got idx=%0d dir=%b arr=%b want 5 0 1", sta_idx, dir, arrive); end
    start = 1'b0;
    for (int n = 0; n < 6; n++) begin
      for (int i = 1; i <= 8; i++) begin
        tick();
        if (i < 8) begin
          checks++; if (arrive !== 1'b0) begin errors++; $display("FAIL bounce_quiet: leg %0d cycle %0d got arr=%b want 0", n, i, arrive); end
        end
      end
      checks++; if (arrive !== 1'b1 || int'(sta_idx) != exp_idx[n] || dir !== exp_dir[n]) begin
        errors++; $display("FAIL bounce_leg%0d: got arr=%b idx=%0d dir=%b want 1 %0d %b", n, arrive, sta_idx, dir, exp_idx[n], exp_dir[n]); end
    end
  endtask

  task automatic test_scroll();
    int s, L, o, k;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    sta_sel = 6'b000100; dir_init = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int st = 0; st < 3; st++) begin
      s = 2 + st;
      L = names[s].len();
      for (int c = 1; c <= 7; c++) begin
        tick();
        o = (L < 4) ? 0 : ((c - 1) / 2) % L;
        k = (ncyc - 1) % 4;
        checks++; if (an !== exp_an()) begin errors++; $display("FAIL scroll_an: sta %0d c %0d got %h want %h", s, c, an, exp_an()); end
        checks++; if (seg !== exp_seg(s, o, k)) begin
          errors++; $display("FAIL scroll_seg: sta %0d c %0d digit %0d got %h want %h", s, c, k, seg, exp_seg(s, o, k)); end
      end
      tick();
      checks++; if (arrive !== 1'b1 || int'(sta_idx) != s + 1) begin
        errors++; $display("FAIL scroll_arrive: got arr=%b idx=%0d want 1 %0d", arrive, sta_idx, s + 1); end
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    sta_sel = 6'b000100; dir_init = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (led_out !== 6'h00 || an !== 4'hF || seg !== 7'h7F) begin
      errors++; $display("FAIL midreset_pins: got led=%h an=%h seg=%h want 00 F 7F", led_out, an, seg); end
    checks++; if (sta_idx !== 3'd0 || dir !== 1'b0 || arrive !== 1'b0) begin
      errors++; $display("FAIL midreset_state: got idx=%0d dir=%b arr=%b want 0 0 0", sta_idx, dir, arrive); end
    rst_n = 1'b1; sta_sel = 6'b000001; dir_init = 1'b1; start = 1'b1;
    tick();
    checks++; if (sta_idx !== 3'd0 || dir !== 1'b1 || arrive !== 1'b1 || led_out !== 6'b000001) begin
      errors++; $display("FAIL restart0: got idx=%0d dir=%b arr=%b led=%b want 0 1 1 000001", sta_idx, dir, arrive, led_out); end
    start = 1'b0;
    repeat (8) tick();
    checks++; if (sta_idx !== 3'd1 || dir !== 1'b0 || arrive !== 1'b1) begin
      errors++; $display("FAIL restart_bounce: got idx=%0d dir=%b arr=%b want 1 0 1", sta_idx, dir, arrive); end
  endtask

`ifdef HOLD_EN
  task automatic test_hold();
    int o, k;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    sta_sel = 6'b000100; dir_init = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      hold = (c >= 3 && c <= 22);
      tick();
      if (c < 28) begin
        o = ((c - 1) / 2) % 10;
        k = (ncyc - 1) % 4;
        checks++; if (arrive !== 1'b0) begin errors++; $display("FAIL hold_quiet: c %0d got arr=%b want 0", c, arrive); end
        checks++; if (seg !== exp_seg(2, o, k)) begin
          errors++; $display("FAIL hold_scroll: c %0d digit %0d got %h want %h", c, k, seg, exp_seg(2, o, k)); end
      end else begin
        checks++; if (arrive !== 1'b1 || sta_idx !== 3'd3) begin
          errors++; $display("FAIL hold_release: got arr=%b idx=%0d want 1 3", arrive, sta_idx); end
      end
    end
    hold = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_start_dwell();
    test_bounce();
    test_scroll();
    test_reset_mid();
`ifdef HOLD_EN
    test_hold();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
